// File: rtl/rc4_pkg.sv
// RC4 shared definitions for the encryptor and the cracker cores.
//   rc4_state_e : FSM states for S init, KSA and PRGA sequencing
//   S_SIZE      : number of entries in the S permutation RAM
//   KEY_BYTES   : secret key length in bytes (24-bit key)
//   key_byte()  : selects one key byte, byte0 being the most significant
package rc4_pkg;

    localparam int S_SIZE    = 256;
    localparam int KEY_BYTES = 3;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        K_RD_I,
        K_RD_J,
        K_WR_I,
        K_WR_J,
        P_RD_I,
        P_RD_J,
        P_WR_I,
        P_WR_J,
        P_RD_F,
        P_XOR,
        DONE
    } rc4_state_e;

    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
        case (idx)
            2'd0:    return key[23:16];
            2'd1:    return key[15:8];
            default: return key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rc4_encryptor.sv
// Single-key RC4 encryption engine.
// Initialises an external 256x8 S RAM, runs the key schedule, then generates
// the keystream and XORs it with a MSG_LEN-byte plaintext ROM, writing the
// ciphertext RAM. All memories are synchronous with 1-cycle read latency.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   start, secret_key     : request (honoured in IDLE) and 24-bit key
//   busy, done            : run in progress / one-cycle completion pulse
//   s_addr/s_wdata/s_we   : S RAM write/read address, data, enable
//   s_rdata               : S RAM read data (one cycle after s_addr)
//   pt_addr/pt_rdata      : plaintext ROM address and data
//   ct_addr/ct_wdata/ct_we: ciphertext RAM write port
module rc4_encryptor
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] secret_key,
    output logic        busy,
    output logic        done,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wdata,
    output logic        s_we,
    input  logic [7:0]  s_rdata,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rdata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wdata,
    output logic        ct_we
);

    localparam logic [7:0] S_LAST   = 8'(S_SIZE - 1);
    localparam logic [7:0] K_LAST   = 8'(MSG_LEN - 1);
    localparam logic [1:0] KIDX_MAX = 2'(KEY_BYTES - 1);

    rc4_state_e  r_state;
    rc4_state_e  w_state_nxt;

    logic [23:0] r_key;
    logic [7:0]  r_i;
    logic [7:0]  r_j;
    logic [7:0]  r_k;
    logic [1:0]  r_kidx;    // i mod 3, kept as a wrapping counter
    logic [7:0]  r_si;
    logic [7:0]  r_sj;
    logic [7:0]  r_pt;

    logic [7:0]  w_key_byte;
    logic [7:0]  w_j_next;
    logic [7:0]  w_i_inc;
    logic [7:0]  w_f_addr;

    assign w_key_byte = key_byte(r_key, r_kidx);
    // Shared j update: KSA adds the key byte, PRGA adds only S[i].
    assign w_j_next   = r_j + s_rdata + ((r_state == K_RD_J) ? w_key_byte : 8'd0);
    assign w_i_inc    = r_i + 8'd1;
    assign w_f_addr   = r_si + r_sj;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        s_addr      = 8'd0;
        s_wdata     = 8'd0;
        s_we        = 1'b0;
        pt_addr     = 8'd0;
        ct_addr     = 8'd0;
        ct_wdata    = 8'd0;
        ct_we       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = INIT;
            end
            INIT: begin
                busy    = 1'b1;
                s_addr  = r_i;
                s_wdata = r_i;
                s_we    = 1'b1;
                if (r_i == S_LAST) w_state_nxt = K_RD_I;
            end
            K_RD_I: begin
                busy        = 1'b1;
                s_addr      = r_i;
                w_state_nxt = K_RD_J;
            end
            K_RD_J: begin
                busy        = 1'b1;
                s_addr      = w_j_next;
                w_state_nxt = K_WR_I;
            end
            K_WR_I: begin
                busy        = 1'b1;
                s_addr      = r_i;
                s_wdata     = s_rdata;
                s_we        = 1'b1;
                w_state_nxt = K_WR_J;
            end
            K_WR_J: begin
                busy        = 1'b1;
                s_addr      = r_j;
                s_wdata     = r_si;
                s_we        = 1'b1;
                w_state_nxt = (r_i == S_LAST) ? P_RD_I : K_RD_I;
            end
            P_RD_I: begin
                busy        = 1'b1;
                s_addr      = w_i_inc;
                w_state_nxt = P_RD_J;
            end
            P_RD_J: begin
                busy        = 1'b1;
                s_addr      = w_j_next;
                w_state_nxt = P_WR_I;
            end
            P_WR_I: begin
                busy        = 1'b1;
                s_addr      = r_i;
                s_wdata     = s_rdata;
                s_we        = 1'b1;
                pt_addr     = r_k;
                w_state_nxt = P_WR_J;
            end
            P_WR_J: begin
                busy        = 1'b1;
                s_addr      = r_j;
                s_wdata     = r_si;
                s_we        = 1'b1;
                w_state_nxt = P_RD_F;
            end
            P_RD_F: begin
                busy        = 1'b1;
                s_addr      = w_f_addr;
                w_state_nxt = P_XOR;
            end
            P_XOR: begin
                busy        = 1'b1;
                ct_addr     = r_k;
                ct_wdata    = s_rdata ^ r_pt;
                ct_we       = 1'b1;
                w_state_nxt = (r_k == K_LAST) ? DONE : P_RD_I;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Index counters: cleared on reset and on every accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_k    <= 8'd0;
            r_kidx <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i    <= 8'd0;
                        r_j    <= 8'd0;
                        r_k    <= 8'd0;
                        r_kidx <= 2'd0;
                    end
                end
                INIT:   r_i <= w_i_inc;   // wraps to 0 for the KSA
                K_RD_J: r_j <= w_j_next;
                K_WR_J: begin
                    r_i    <= w_i_inc;    // wraps to 0 for the PRGA
                    r_kidx <= (r_kidx == KIDX_MAX) ? 2'd0 : r_kidx + 2'd1;
                    if (r_i == S_LAST) begin
                        r_j <= 8'd0;
                        r_k <= 8'd0;
                    end
                end
                P_RD_I: r_i <= w_i_inc;
                P_RD_J: r_j <= w_j_next;
                P_XOR:  r_k <= r_k + 8'd1;
                default: ;
            endcase
        end
    end

    // Data captures carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) r_key <= secret_key;
        if (r_state == K_RD_J || r_state == P_RD_J) r_si <= s_rdata;
        if (r_state == K_WR_I || r_state == P_WR_I) r_sj <= s_rdata;
        if (r_state == P_WR_J) r_pt <= pt_rdata;
    end

endmodule

// File: tb/tb_rc4_encryptor.sv
module tb_rc4_encryptor;

    localparam int MSG_LEN = 32;
    localparam int BUSY_EXP = 256 + 1024 + 6 * MSG_LEN;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [23:0] secret_key;
    logic        busy;
    logic        done;
    logic [7:0]  s_addr;
    logic [7:0]  s_wdata;
    logic        s_we;
    logic [7:0]  s_rdata;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rdata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wdata;
    logic        ct_we;

    logic [7:0]  smem  [256];
    logic [7:0]  ptmem [256];
    logic [7:0]  ctmem [256];
    logic [7:0]  ks    [MSG_LEN];
    logic [7:0]  kv_ct [9];
    logic [7:0]  kv_pt [9];

    logic [15:0] ct_q [$];
    logic [15:0] s_q  [$];

    int n_chk = 0;
    int n_err = 0;

    rc4_encryptor #(.MSG_LEN(MSG_LEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .secret_key (secret_key),
        .busy       (busy),
        .done       (done),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_we       (s_we),
        .s_rdata    (s_rdata),
        .pt_addr    (pt_addr),
        .pt_rdata   (pt_rdata),
        .ct_addr    (ct_addr),
        .ct_wdata   (ct_wdata),
        .ct_we      (ct_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories, 1-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (s_we) smem[s_addr] <= s_wdata;
        s_rdata  <= smem[s_addr];
        pt_rdata <= ptmem[pt_addr];
        if (ct_we) ctmem[ct_addr] <= ct_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected writes whenever the DUT writes.
    always @(negedge clk) begin
        logic [15:0] e;
        if (ct_we) begin
            if (ct_q.size() == 0) begin
                chk("ct_unexpected_write", 32'(ct_addr), 32'hFFFF_FFFF);
            end else begin
                e = ct_q.pop_front();
                chk($sformatf("ct_addr k=%0d", e[15:8]), 32'(ct_addr), 32'(e[15:8]));
                chk($sformatf("ct_data k=%0d", e[15:8]), 32'(ct_wdata), 32'(e[7:0]));
            end
        end
        if (s_we && s_q.size() > 0) begin
            e = s_q.pop_front();
            chk($sformatf("s_wr_addr exp=%0d", e[15:8]), 32'(s_addr), 32'(e[15:8]));
            chk($sformatf("s_wr_data a=%0d", e[15:8]), 32'(s_wdata), 32'(e[7:0]));
        end
    end

    // Textbook RC4 reference producing the first MSG_LEN keystream bytes.
    task automatic gen_ks(input logic [23:0] key);
        int S [256];
        int kb [3];
        int i, j, t;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int n = 0; n < 256; n++) S[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + S[n] + kb[n % 3]) % 256;
            t = S[n]; S[n] = S[j]; S[j] = t;
        end
        i = 0; j = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = (i + 1) % 256;
            j = (j + S[i]) % 256;
            t = S[i]; S[i] = S[j]; S[j] = t;
            ks[k] = 8'(S[(S[i] + S[j]) % 256]);
        end
    endtask

    task automatic push_ct(input int n);
        for (int k = 0; k < n; k++) ct_q.push_back({8'(k), ks[k] ^ ptmem[k]});
    endtask

    task automatic run(input logic [23:0] key, input int restart_at,
                       input logic [23:0] rkey, input string tag);
        int busy_cyc;
        int done_cnt;
        @(negedge clk);
        secret_key = key;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c == restart_at) begin
                secret_key = rkey;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(BUSY_EXP));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " sb_drain"}, 32'(ct_q.size()), 32'd0);
    endtask

    initial begin
        int seen;
        int wr_after;
        logic [23:0] rkeys [3];

        for (int n = 0; n < 256; n++) begin
            smem[n]  = 8'h00;
            ptmem[n] = 8'h00;
            ctmem[n] = 8'h00;
        end
        kv_pt[0] = 8'h50; kv_pt[1] = 8'h6C; kv_pt[2] = 8'h61;
        kv_pt[3] = 8'h69; kv_pt[4] = 8'h6E; kv_pt[5] = 8'h74;
        kv_pt[6] = 8'h65; kv_pt[7] = 8'h78; kv_pt[8] = 8'h74;
        kv_ct[0] = 8'hBB; kv_ct[1] = 8'hF3; kv_ct[2] = 8'h16;
        kv_ct[3] = 8'hE8; kv_ct[4] = 8'hD9; kv_ct[5] = 8'h40;
        kv_ct[6] = 8'hAF; kv_ct[7] = 8'h0A; kv_ct[8] = 8'hD3;
        rkeys[0] = 24'hA5C3F0;
        rkeys[1] = 24'hFFFFFF;
        rkeys[2] = 24'h000000;

        // Reset with start held high: nothing may begin.
        reset_n = 1'b0;
        start = 1'b1;
        secret_key = 24'h123456;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst s_we", 32'(s_we), 32'd0);
        chk("rst ct_we", 32'(ct_we), 32'd0);
        chk("rst s_addr", 32'(s_addr), 32'd0);
        chk("rst s_wdata", 32'(s_wdata), 32'd0);
        chk("rst pt_addr", 32'(pt_addr), 32'd0);
        chk("rst ct_addr", 32'(ct_addr), 32'd0);
        chk("rst ct_wdata", 32'(ct_wdata), 32'd0);
        reset_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle s_we", 32'(s_we), 32'd0);

        // INIT writes S[n]=n, then the first KSA swap: S[0]=01, S[1]=00.
        for (int n = 0; n < 256; n++) s_q.push_back({8'(n), 8'(n)});
        s_q.push_back({8'd0, 8'h01});
        s_q.push_back({8'd1, 8'h00});
        gen_ks(24'h010203);
        push_ct(MSG_LEN);
        run(24'h010203, -1, 24'h0, "key010203");
        chk("s_q drained", 32'(s_q.size()), 32'd0);

        // Known vector: key "Key", plaintext "Plaintext".
        for (int n = 0; n < 9; n++) ptmem[n] = kv_pt[n];
        gen_ks(24'h4B6579);
        for (int k = 0; k < MSG_LEN; k++)
            ct_q.push_back({8'(k), (k < 9) ? kv_ct[k] : ks[k]});
        run(24'h4B6579, -1, 24'h0, "key_Key");
        for (int n = 0; n < 9; n++) ptmem[n] = 8'h00;

        // Zero plaintext: ciphertext is the raw keystream.
        for (int r = 0; r < 3; r++) begin
            gen_ks(rkeys[r]);
            push_ct(MSG_LEN);
            run(rkeys[r], -1, 24'h0, $sformatf("zero_pt%0d", r));
        end

        // A second start during KSA must be ignored.
        gen_ks(24'h3C5A96);
        push_ct(MSG_LEN);
        run(24'h3C5A96, 400, 24'h777777, "restart_ign");

        // Reset during PRGA byte k=5.
        gen_ks(24'hC0FFEE);
        push_ct(5);
        @(negedge clk);
        secret_key = 24'hC0FFEE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 2000 && seen < 5; c++) begin
            if (ct_we) seen++;
            if (seen < 5) @(negedge clk);
        end
        chk("abort ct_writes_before", 32'(seen), 32'd5);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort s_we", 32'(s_we), 32'd0);
        chk("abort ct_we", 32'(ct_we), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wr_after = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_we || ct_we || busy) wr_after++;
        end
        chk("abort quiet", 32'(wr_after), 32'd0);
        chk("abort sb_drain", 32'(ct_q.size()), 32'd0);
        push_ct(MSG_LEN);
        run(24'hC0FFEE, -1, 24'h0, "after_abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
